// File: rtl/mux_bus_regfile.sv
// mux_bus_regfile: clocked register file behind an async,
// multiplexed ALE/RD/WR CPU bus with sticky error status.
module mux_bus_regfile #(
    parameter int              DW        = 8,
    parameter int              NOUT      = 4,
    parameter int              NIN       = 4,
    parameter logic [DW-1:0]   RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [DW-1:0]      bus_in,
    output logic [DW-1:0]      bus_out,
    output logic               bus_oe,
    input  logic               ale,
    input  logic               rd,
    input  logic               wr,
    output logic [NOUT*DW-1:0] out_regs,
    input  logic [NIN*DW-1:0]  in_regs,
    output logic               wr_stb,
    output logic               rd_stb,
    output logic               err
);

    if (64'(NOUT + NIN + 1) > (64'd1 << DW)) begin : g_size_chk
        $error("mux_bus_regfile: NOUT+NIN+1 exceeds 2**DW");
    end

    localparam logic [DW-1:0] A_ST = DW'(NOUT + NIN);

    logic [1:0]    ale_q, rd_q, wr_q;
    logic [DW-1:0] bus_m, bus_s;
    logic          ale_s, rd_s, wr_s;
    logic          ale_p, rd_p, wr_p;
    logic [1:0]    vld;
    logic          armed;
    logic [DW-1:0] addr, wdata;
    logic          wvalid, stat_rd, oe_blk;
    logic [DW-1:0] oreg [NOUT];

    logic          rd_rise, rd_fall, wr_rise, wr_fall;
    logic          rw_conf, ale_conf, addr_ld, do_rd;
    logic          addr_out, addr_bad, commit, err_set;
    logic [DW-1:0] rmux;

    assign ale_s = ale_q[1];
    assign rd_s  = rd_q[1];
    assign wr_s  = wr_q[1];

    for (genvar i = 0; i < NOUT; i++) begin : g_out
        assign out_regs[i*DW +: DW] = oreg[i];
    end

    always_comb begin
        rd_rise  = armed & rd_s & ~rd_p;
        rd_fall  = armed & ~rd_s & rd_p;
        wr_rise  = armed & wr_s & ~wr_p;
        wr_fall  = armed & ~wr_s & wr_p;
        rw_conf  = armed & rd_s & wr_s;
        ale_conf = armed & ale_s & (rd_s | wr_s);
        addr_ld  = armed & ale_s & ale_p & ~rd_s & ~wr_s;
        do_rd    = rd_rise & ~rw_conf & ~oe_blk;
        addr_out = addr < DW'(NOUT);
        addr_bad = addr > A_ST;
        commit   = wr_fall & wvalid;
        err_set  = rw_conf | ale_conf | (commit & ~addr_out)
                 | (do_rd & addr_bad);
    end

    always_comb begin
        rmux = '0;
        for (int i = 0; i < NOUT; i++)
            if (addr == DW'(i)) rmux = oreg[i];
        for (int j = 0; j < NIN; j++)
            if (addr == DW'(NOUT + j)) rmux = in_regs[j*DW +: DW];
        if (addr == A_ST) rmux = {{(DW-1){1'b0}}, err};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ale_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            bus_m   <= '0;
            bus_s   <= '0;
            ale_p   <= 1'b0;
            rd_p    <= 1'b0;
            wr_p    <= 1'b0;
            vld     <= '0;
            armed   <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            wvalid  <= 1'b0;
            stat_rd <= 1'b0;
            oe_blk  <= 1'b0;
            bus_out <= '0;
            bus_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            rd_stb  <= 1'b0;
            err     <= 1'b0;
            for (int i = 0; i < NOUT; i++) oreg[i] <= RESET_VAL;
        end else begin
            ale_q <= {ale_q[0], ale};
            rd_q  <= {rd_q[0], rd};
            wr_q  <= {wr_q[0], wr};
            bus_m <= bus_in;
            bus_s <= bus_m;
            ale_p <= ale_s;
            rd_p  <= rd_s;
            wr_p  <= wr_s;
            // vld covers the sync pipe refill so a held strobe blocks arming
            vld   <= {vld[0], 1'b1};
            if (vld[1] & ~ale_s & ~rd_s & ~wr_s) armed <= 1'b1;

            if (addr_ld) addr <= bus_s;
            if (armed & wr_s & wr_p) wdata <= bus_s;
            if (rw_conf | wr_fall) wvalid <= 1'b0;
            else if (wr_rise)      wvalid <= 1'b1;

            wr_stb <= commit & addr_out;
            for (int i = 0; i < NOUT; i++)
                if (commit & addr_out & (addr == DW'(i))) oreg[i] <= wdata;

            rd_stb <= do_rd & ~addr_bad;
            if (do_rd) bus_out <= rmux;
            if (~rd_s | rw_conf | oe_blk) bus_oe <= 1'b0;
            else if (do_rd)              bus_oe <= 1'b1;

            if (rw_conf)            oe_blk <= 1'b1;
            else if (~rd_s & ~wr_s) oe_blk <= 1'b0;

            if (do_rd)                   stat_rd <= (addr == A_ST);
            else if (rd_fall | rw_conf)  stat_rd <= 1'b0;

            if (err_set)                err <= 1'b1;
            else if (rd_fall & stat_rd) err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_bus_regfile.sv
// tb_mux_bus_regfile: transaction-level model check of two
// mux_bus_regfile configurations (8-bit 4/4 and 16-bit 2/1).
module tb_mux_bus_regfile;

    localparam int DW0 = 8,  NO0 = 4, NI0 = 4;
    localparam int DW1 = 16, NO1 = 2, NI1 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] bus = '0;
    logic [1:0]  ale = '0, rd = '0, wr = '0;

    logic [DW0-1:0]     bo0;
    logic               oe0, ws0, rs0, er0;
    logic [NO0*DW0-1:0] or0;
    logic [NI0*DW0-1:0] ir0 = '0;

    logic [DW1-1:0]     bo1;
    logic               oe1, ws1, rs1, er1;
    logic [NO1*DW1-1:0] or1;
    logic [NI1*DW1-1:0] ir1 = '0;

    mux_bus_regfile #(.DW(DW0), .NOUT(NO0), .NIN(NI0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus_in(bus[7:0]), .bus_out(bo0),
        .bus_oe(oe0), .ale(ale[0]), .rd(rd[0]), .wr(wr[0]),
        .out_regs(or0), .in_regs(ir0), .wr_stb(ws0), .rd_stb(rs0),
        .err(er0));

    mux_bus_regfile #(.DW(DW1), .NOUT(NO1), .NIN(NI1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus_in(bus), .bus_out(bo1),
        .bus_oe(oe1), .ale(ale[1]), .rd(rd[1]), .wr(wr[1]),
        .out_regs(or1), .in_regs(ir1), .wr_stb(ws1), .rd_stb(rs1),
        .err(er1));

    int checks = 0;
    int errors = 0;

    logic [15:0] m_out [2][8];
    bit          m_err [2];
    int          m_ws [2], m_rs [2];
    int          nws [2], nrs [2];
    bit          oe_seen [2];
    bit          quiet = 1'b0;
    logic [15:0] last_rd;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int nout(int s); return s ? NO1 : NO0; endfunction
    function automatic int nin(int s);  return s ? NI1 : NI0; endfunction
    function automatic logic [15:0] msk(int s);
        return s ? 16'hFFFF : 16'h00FF;
    endfunction
    function automatic logic [15:0] in_val(int s, int j);
        return s ? ir1[j*16 +: 16] : {8'h00, ir0[j*8 +: 8]};
    endfunction
    function automatic logic oe(int s); return s ? oe1 : oe0; endfunction
    function automatic logic ws(int s); return s ? ws1 : ws0; endfunction
    function automatic logic [15:0] bout(int s);
        return s ? bo1 : {8'h00, bo0};
    endfunction

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 8; i++) m_out[s][i] = '0;
            m_err[s] = 1'b0;
        end
    endfunction

    // per-cycle compare of settled outputs against the model
    initial forever begin
        @(posedge clk);
        #1;
        if (oe0) oe_seen[0] = 1'b1;
        if (oe1) oe_seen[1] = 1'b1;
        if (ws0) nws[0]++;
        if (ws1) nws[1]++;
        if (rs0) nrs[0]++;
        if (rs1) nrs[1]++;
        if (quiet) begin
            for (int i = 0; i < NO0; i++)
                chk("out0", 32'(or0[i*8 +: 8]), 32'(m_out[0][i][7:0]));
            for (int i = 0; i < NO1; i++)
                chk("out1", 32'(or1[i*16 +: 16]), 32'(m_out[1][i]));
            chk("err0", 32'(er0), 32'(m_err[0]));
            chk("err1", 32'(er1), 32'(m_err[1]));
            chk("oe_idle", 32'({oe1, oe0}), 32'd0);
        end
    end

    task automatic addr_phase(int s, int a);
        bus = 16'(a);
        ale[s] = 1'b1;
        repeat (5) @(negedge clk);
        ale[s] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_write(int s, int a, logic [15:0] d);
        int n;
        quiet = 1'b0;
        addr_phase(s, a);
        bus = d;
        wr[s] = 1'b1;
        repeat (5) @(negedge clk);
        wr[s] = 1'b0;
        if (a < nout(s)) begin
            n = 0;
            while (!ws(s) && n < 8) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("wr_stb_seen", 32'(ws(s)), 32'd1);
            chk("wr_lat", 32'(n >= 3 && n <= 4), 32'd1);
            m_out[s][a] = d & msk(s);
            m_ws[s]++;
            repeat (5) @(negedge clk);
        end else begin
            m_err[s] = 1'b1;
            repeat (8) @(negedge clk);
        end
        chk("wr_stb_cnt", 32'(nws[s]), 32'(m_ws[s]));
        quiet = 1'b1;
    endtask

    task automatic do_read(int s, int a);
        logic [15:0] exp;
        int n;
        quiet = 1'b0;
        if (a < nout(s))                exp = m_out[s][a];
        else if (a < nout(s) + nin(s))  exp = in_val(s, a - nout(s));
        else if (a == nout(s) + nin(s)) exp = {15'd0, m_err[s]};
        else                            exp = '0;
        addr_phase(s, a);
        rd[s] = 1'b1;
        n = 0;
        while (!oe(s) && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rd_oe", 32'(oe(s)), 32'd1);
        chk("rd_lat", 32'(n >= 3 && n <= 4), 32'd1);
        chk("rd_data", 32'(bout(s)), 32'(exp));
        last_rd = bout(s);
        repeat (3) @(negedge clk);
        rd[s] = 1'b0;
        repeat (6) @(negedge clk);
        chk("rd_oe_drop", 32'(oe(s)), 32'd0);
        chk("rd_hold", 32'(bout(s)), 32'(exp));
        if (a > nout(s) + nin(s)) m_err[s] = 1'b1;
        else m_rs[s]++;
        if (a == nout(s) + nin(s)) m_err[s] = 1'b0;
        chk("rd_stb_cnt", 32'(nrs[s]), 32'(m_rs[s]));
        quiet = 1'b1;
    endtask

    task automatic do_conflict(int s, int a);
        quiet = 1'b0;
        addr_phase(s, a);
        bus = 16'h00CC;
        oe_seen[s] = 1'b0;
        rd[s] = 1'b1;
        wr[s] = 1'b1;
        repeat (5) @(negedge clk);
        rd[s] = 1'b0;
        wr[s] = 1'b0;
        repeat (8) @(negedge clk);
        m_err[s] = 1'b1;
        chk("conf_oe", 32'(oe_seen[s]), 32'd0);
        chk("conf_wr_stb", 32'(nws[s]), 32'(m_ws[s]));
        chk("conf_rd_stb", 32'(nrs[s]), 32'(m_rs[s]));
        quiet = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        model_reset();
        for (int s = 0; s < 2; s++) begin
            m_ws[s] = 0; m_rs[s] = 0; nws[s] = 0; nrs[s] = 0;
            oe_seen[s] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(or0), 32'd0);
        chk("rst_oe", 32'({oe1, oe0}), 32'd0);
        chk("rst_bus_out", 32'(bo0), 32'd0);
        chk("rst_stb", 32'({ws0, rs0, ws1, rs1}), 32'd0);
        chk("rst_err", 32'({er1, er0}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        quiet = 1'b1;

        do_write(0, 0, 16'h00A5);
        do_write(0, 1, 16'h005A);
        chk("lit_out0", 32'(or0[7:0]), 32'h0000_00A5);
        chk("lit_out1", 32'(or0[15:8]), 32'h0000_005A);
        chk("lit_wr_cnt", 32'(nws[0]), 32'd2);

        ir0 = 32'h0000_0033;
        do_read(0, 4);
        chk("lit_in0", 32'(last_rd), 32'h33);
        do_read(0, 0);
        chk("lit_rd0", 32'(last_rd), 32'hA5);

        do_write(0, 9, 16'h0077);
        chk("lit_err_set", 32'(er0), 32'd1);
        do_read(0, 8);
        chk("lit_status1", 32'(last_rd), 32'h01);
        chk("lit_err_clr", 32'(er0), 32'd0);
        do_read(0, 8);
        chk("lit_status0", 32'(last_rd), 32'h00);

        do_conflict(0, 2);
        chk("lit_conf_err", 32'(er0), 32'd1);
        chk("lit_conf_out2", 32'(or0[23:16]), 32'd0);

        // reset while a write to addr 3 is in flight
        quiet = 1'b0;
        addr_phase(0, 3);
        bus = 16'h00FF;
        wr[0] = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        wr[0] = 1'b0;
        repeat (8) @(negedge clk);
        model_reset();
        chk("rst_mid_out3", 32'(or0[31:24]), 32'd0);
        chk("rst_mid_wr_stb", 32'(nws[0]), 32'(m_ws[0]));
        quiet = 1'b1;
        do_write(0, 3, 16'h0012);
        chk("lit_out3", 32'(or0[31:24]), 32'h12);

        for (int k = 0; k < 40; k++) begin
            int kind, a;
            kind = $urandom_range(0, 5);
            a = $urandom_range(0, 10);
            if (kind < 3) begin
                do_write(0, a, 16'($urandom));
            end else if (kind < 5) begin
                ir0 = $urandom;
                @(negedge clk);
                do_read(0, a);
            end else begin
                do_conflict(0, a);
            end
        end

        do_write(1, 1, 16'hBEEF);
        ir1 = 16'h1234;
        @(negedge clk);
        do_read(1, 2);
        chk("lit16_in", 32'(last_rd), 32'h1234);
        do_read(1, 3);
        chk("lit16_status", 32'(last_rd), 32'h0000);
        do_read(1, 1);
        chk("lit16_rd1", 32'(last_rd), 32'hBEEF);
        chk("lit16_out1", 32'(or1[31:16]), 32'hBEEF);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
